// File: rtl/afc_sar_engine_if.sv
// ---------------------------------------------------------------------------
// afc_sar_engine_if
//
// Groups the control and result signals of the AFC SAR engine.
// refclk and rst are not part of the bundle; they stay plain module ports.
//
// Signals:
//   afctrigger        start request, level-sampled while the engine is idle
//   div_pulse         one-cycle pulse per divided-clock rising edge (refclk domain)
//   target_count      expected div_pulse count per measurement window
//   control_code_out  current oscillator control code
//   meas_count        edge count of the last completed window
//   busy              search in progress
//   done              one-cycle pulse when a search finishes
//   afc_status        lock flag, held until the next start
//
// Modports:
//   master  stimulus side: drives afctrigger, div_pulse, target_count
//   slave   engine side:   drives control_code_out, meas_count, busy, done,
//                          afc_status
// ---------------------------------------------------------------------------
interface afc_sar_engine_if #(
  parameter int CODE_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   afctrigger;
  logic                   div_pulse;
  logic [COUNT_WIDTH-1:0] target_count;
  logic [CODE_WIDTH-1:0]  control_code_out;
  logic [COUNT_WIDTH-1:0] meas_count;
  logic                   busy;
  logic                   done;
  logic                   afc_status;

  modport master (
    output afctrigger,
    output div_pulse,
    output target_count,
    input  control_code_out,
    input  meas_count,
    input  busy,
    input  done,
    input  afc_status
  );

  modport slave (
    input  afctrigger,
    input  div_pulse,
    input  target_count,
    output control_code_out,
    output meas_count,
    output busy,
    output done,
    output afc_status
  );
endinterface

// File: rtl/afc_sar_engine.sv
// ---------------------------------------------------------------------------
// afc_sar_engine
//
// Successive-approximation AFC engine. Searches a CODE_WIDTH-bit oscillator
// control code, MSB first, until the number of div_pulse events counted over
// a WINDOW-cycle refclk window is within TOL of the programmed target. Every
// code change is followed by SETTLE idle cycles before counting starts. After
// the last bit has been decided, one more measurement verifies the final code.
//
// Optional feature (compile-time macro AFC_FINE_TUNE_EN):
//   when defined, a failed verification is followed by up to MAX_FINE
//   +/-1 linear steps of the code, each with its own measurement.
//   When undefined, a failed verification ends the search unlocked.
//
// Ports:
//   refclk   in   sole clock
//   rst      in   synchronous, active-high reset
//   io_bus   slave modport of afc_sar_engine_if:
//              afctrigger, div_pulse, target_count  (in)
//              control_code_out, meas_count, busy, done, afc_status  (out)
// ---------------------------------------------------------------------------
module afc_sar_engine #(
  parameter int CODE_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int WINDOW      = 1024,
  parameter int SETTLE      = 16,
  parameter int TOL         = 2,
  parameter int MAX_FINE    = 4
) (
  input  logic            refclk,
  input  logic            rst,
  afc_sar_engine_if.slave io_bus
);

  localparam int CYC_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CYC_W   = $clog2(CYC_MAX) + 1;
  localparam int BIT_W   = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;

  localparam logic [CODE_WIDTH-1:0]  CODE_MSB    = CODE_WIDTH'(1) << (CODE_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] EDGE_MAX    = '1;
  localparam logic [COUNT_WIDTH:0]   TOL_V       = (COUNT_WIDTH + 1)'(TOL);
  localparam logic [CYC_W-1:0]       SETTLE_LAST = CYC_W'(SETTLE - 1);
  localparam logic [CYC_W-1:0]       WINDOW_LAST = CYC_W'(WINDOW - 1);
`ifdef AFC_FINE_TUNE_EN
  localparam int FINE_W = $clog2(MAX_FINE + 1) + 1;
  localparam logic [CODE_WIDTH-1:0] CODE_MAX  = '1;
  localparam logic [FINE_W-1:0]     FINE_LAST = FINE_W'(MAX_FINE);
`endif

  // S_VERIFY is the decision that follows the verification measurement (and,
  // with fine tuning, every fine-step measurement).
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE,
    S_VERIFY,
    S_DONE
`ifdef AFC_FINE_TUNE_EN
    , S_FINE
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CODE_WIDTH-1:0]  r_code,     w_code_next;
  logic [BIT_W-1:0]       r_bit_idx,  w_bit_idx_next;
  logic [COUNT_WIDTH-1:0] r_target,   w_target_next;
  logic [COUNT_WIDTH-1:0] r_edge,     w_edge_next;
  logic [COUNT_WIDTH-1:0] r_meas,     w_meas_next;
  logic [CYC_W-1:0]       r_cyc,      w_cyc_next;
  logic                   r_status,   w_status_next;
  logic                   r_verify,   w_verify_next;
`ifdef AFC_FINE_TUNE_EN
  logic [FINE_W-1:0]      r_fine_cnt, w_fine_cnt_next;
`endif

  logic [COUNT_WIDTH-1:0] w_edge_inc;
  logic [COUNT_WIDTH:0]   w_diff;
  logic [COUNT_WIDTH:0]   w_abs_diff;
  logic                   w_meas_lt;
  logic                   w_within;

  // Edge counter sticks at all-ones instead of wrapping.
  assign w_edge_inc = (io_bus.div_pulse && (r_edge != EDGE_MAX)) ?
                      r_edge + COUNT_WIDTH'(1) : r_edge;

  // One extra bit makes the zero-extended difference a valid signed value.
  assign w_diff     = {1'b0, r_meas} - {1'b0, r_target};
  assign w_meas_lt  = w_diff[COUNT_WIDTH];
  assign w_abs_diff = w_meas_lt ? ((COUNT_WIDTH + 1)'(0) - w_diff) : w_diff;
  assign w_within   = (w_abs_diff <= TOL_V);

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_code     <= '0;
      r_bit_idx  <= '0;
      r_target   <= '0;
      r_edge     <= '0;
      r_meas     <= '0;
      r_cyc      <= '0;
      r_status   <= 1'b0;
      r_verify   <= 1'b0;
`ifdef AFC_FINE_TUNE_EN
      r_fine_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_code     <= w_code_next;
      r_bit_idx  <= w_bit_idx_next;
      r_target   <= w_target_next;
      r_edge     <= w_edge_next;
      r_meas     <= w_meas_next;
      r_cyc      <= w_cyc_next;
      r_status   <= w_status_next;
      r_verify   <= w_verify_next;
`ifdef AFC_FINE_TUNE_EN
      r_fine_cnt <= w_fine_cnt_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_code_next     = r_code;
    w_bit_idx_next  = r_bit_idx;
    w_target_next   = r_target;
    w_edge_next     = r_edge;
    w_meas_next     = r_meas;
    w_cyc_next      = r_cyc;
    w_status_next   = r_status;
    w_verify_next   = r_verify;
`ifdef AFC_FINE_TUNE_EN
    w_fine_cnt_next = r_fine_cnt;
`endif

    case (r_state)
      S_IDLE, S_DONE: begin
        if (io_bus.afctrigger) begin
          w_target_next   = io_bus.target_count;
          w_bit_idx_next  = BIT_W'(CODE_WIDTH - 1);
          w_code_next     = CODE_MSB;
          w_status_next   = 1'b0;
          w_verify_next   = 1'b0;
          w_cyc_next      = '0;
`ifdef AFC_FINE_TUNE_EN
          w_fine_cnt_next = '0;
`endif
          w_state_next    = S_SETTLE;
        end else if (r_state == S_DONE) begin
          // DONE lasts one cycle so that done is a single pulse.
          w_state_next = S_IDLE;
        end
      end

      S_SETTLE: begin
        if (r_cyc == SETTLE_LAST) begin
          w_cyc_next   = '0;
          w_edge_next  = '0;
          w_state_next = S_MEASURE;
        end else begin
          w_cyc_next = r_cyc + CYC_W'(1);
        end
      end

      S_MEASURE: begin
        w_edge_next = w_edge_inc;
        if (r_cyc == WINDOW_LAST) begin
          // A pulse on the final window cycle is included in the result.
          w_meas_next  = w_edge_inc;
          w_cyc_next   = '0;
          w_state_next = r_verify ? S_VERIFY : S_DECIDE;
        end else begin
          w_cyc_next = r_cyc + CYC_W'(1);
        end
      end

      S_DECIDE: begin
        if (w_within) begin
          w_status_next = 1'b1;
          w_state_next  = S_DONE;
        end else begin
          // Higher code = faster oscillator: keep the trial bit only when slow.
          if (!w_meas_lt) begin
            w_code_next[r_bit_idx] = 1'b0;
          end
          if (r_bit_idx != '0) begin
            w_code_next[r_bit_idx - BIT_W'(1)] = 1'b1;
            w_bit_idx_next = r_bit_idx - BIT_W'(1);
          end else begin
            w_verify_next = 1'b1;
          end
          w_state_next = S_SETTLE;
        end
      end

      S_VERIFY: begin
        if (w_within) begin
          w_status_next = 1'b1;
          w_state_next  = S_DONE;
`ifdef AFC_FINE_TUNE_EN
        end else if (r_fine_cnt == FINE_LAST) begin
          w_status_next = 1'b0;
          w_state_next  = S_DONE;
        end else begin
          w_state_next = S_FINE;
        end
`else
        end else begin
          w_status_next = 1'b0;
          w_state_next  = S_DONE;
        end
`endif
      end

`ifdef AFC_FINE_TUNE_EN
      S_FINE: begin
        // A step that would leave the code range ends the search unlocked.
        if (w_meas_lt ? (r_code == CODE_MAX) : (r_code == '0)) begin
          w_status_next = 1'b0;
          w_state_next  = S_DONE;
        end else begin
          w_code_next     = w_meas_lt ? r_code + CODE_WIDTH'(1) : r_code - CODE_WIDTH'(1);
          w_fine_cnt_next = r_fine_cnt + FINE_W'(1);
          w_cyc_next      = '0;
          w_state_next    = S_SETTLE;
        end
      end
`endif

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign io_bus.control_code_out = r_code;
  assign io_bus.meas_count       = r_meas;
  assign io_bus.busy             = (r_state != S_IDLE) && (r_state != S_DONE);
  assign io_bus.done             = (r_state == S_DONE);
  assign io_bus.afc_status       = r_status;

endmodule
